// File: rtl/galaxian_rom_loader.sv
// galaxian_rom_loader: turns the data_io ioctl byte stream into ROM-region write strobes and sequences the galaxian core reset.
// Ports: clk_sys/reset (async, active-high); ioctl_download/index/wr/addr/dout from data_io;
// wr_addr/wr_data with pgm_we, gfxk_we, gfxh_we and prom_we region strobes; core_reset and load_done
// for the core; load_err and byte_count report on the current or last download.
module galaxian_rom_loader #(
  parameter int          HOLD_CYCLES = 1024,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [15:0] EXP_BYTES   = 16'h6020
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        pgm_we,
  output logic        gfxk_we,
  output logic        gfxh_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] byte_count
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  state_t state_q, state_d;
  logic wr_prev_q, hit_q, hit_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, wr_data_q, wr_data_d;
  logic [13:0] wr_addr_q, wr_addr_d;
  logic pgm_q, pgm_d, gfxk_q, gfxk_d, gfxh_q, gfxh_d, prom_q, prom_d;
  logic [15:0] count_q, count_d, hold_q, hold_d;
  logic oor_q, oor_d, err_q, err_d;
  logic start, rise, finish, in_rng;
  always_comb begin
    start = ioctl_download && ioctl_index == ROM_INDEX && state_q != LOAD;
    rise = state_q == LOAD && ioctl_wr && !wr_prev_q;
    // Leaving LOAD waits until any captured byte has been strobed, so strobes stay inside LOAD
    // and the error verdict sees the final count.
    finish = state_q == LOAD && !ioctl_download && !rise && !hit_q;
    hit_d = rise;
    addr_d = rise ? ioctl_addr : addr_q;
    data_d = rise ? ioctl_dout : data_q;
    pgm_d = hit_q && addr_q[24:14] == 11'd0;
    gfxk_d = hit_q && addr_q[24:12] == 13'h004;
    gfxh_d = hit_q && addr_q[24:12] == 13'h005;
    prom_d = hit_q && addr_q[24:5] == 20'h00300;
    in_rng = pgm_d || gfxk_d || gfxh_d || prom_d;
    wr_addr_d = !in_rng ? wr_addr_q : pgm_d ? addr_q[13:0] : prom_d ? {9'b0, addr_q[4:0]} : {2'b0, addr_q[11:0]};
    wr_data_d = in_rng ? data_q : wr_data_q;
    count_d = start ? 16'd0 : (in_rng && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    oor_d = !start && (oor_q || (hit_q && !in_rng));
    err_d = start ? 1'b0 : finish ? (oor_q || count_q != EXP_BYTES) : err_q;
    hold_d = state_q == HOLD ? hold_q + 16'd1 : 16'd0;
    state_d = start ? LOAD : finish ? HOLD : (state_q == HOLD && hold_q == 16'(HOLD_CYCLES - 1)) ? RUN : state_q;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_prev_q <= 1'b0;
      hit_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pgm_q <= 1'b0;
      gfxk_q <= 1'b0;
      gfxh_q <= 1'b0;
      prom_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q <= '0;
      hold_q <= '0;
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_prev_q <= ioctl_wr;
      hit_q <= hit_d;
      addr_q <= addr_d;
      data_q <= data_d;
      pgm_q <= pgm_d;
      gfxk_q <= gfxk_d;
      gfxh_q <= gfxh_d;
      prom_q <= prom_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q <= count_d;
      hold_q <= hold_d;
      oor_q <= oor_d;
      err_q <= err_d;
    end
  end
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pgm_we = pgm_q;
  assign gfxk_we = gfxk_q;
  assign gfxh_we = gfxh_q;
  assign prom_we = prom_q;
  assign core_reset = state_q != RUN;
  assign load_done = state_q == RUN;
  assign load_err = err_q;
  assign byte_count = count_q;
endmodule

// File: tb/tb_galaxian_rom_loader.sv
// tb_galaxian_rom_loader: randomized scoreboard bench for galaxian_rom_loader.
module tb_galaxian_rom_loader;
  localparam int HOLD = 1024;
  localparam int EXP = 'h6020;
  typedef struct {int rg; logic [13:0] a; logic [7:0] d; int due;} exp_t;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0] ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [13:0] wr_addr;
  logic [7:0] wr_data;
  logic pgm_we, gfxk_we, gfxh_we, prom_we, core_reset, load_done, load_err;
  logic [15:0] byte_count;
  int tests = 0, fails = 0, cyc = 0, m_count = 0;
  bit m_oor = 1'b0;
  int cnt[4];
  exp_t sbq[$];
  galaxian_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .wr_addr(wr_addr),
    .wr_data(wr_data), .pgm_we(pgm_we), .gfxk_we(gfxk_we), .gfxh_we(gfxh_we), .prom_we(prom_we),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err), .byte_count(byte_count)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;
  function automatic int region_of(input logic [24:0] a);
    return a < 25'h4000 ? 0 : a < 25'h5000 ? 1 : a < 25'h6000 ? 2 : a < 25'h6020 ? 3 : 4;
  endfunction
  function automatic int base_of(input int r);
    return r == 0 ? 0 : r == 1 ? 'h4000 : r == 2 ? 'h5000 : 'h6000;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_sys) begin
    int n, rg;
    exp_t e;
    n = int'(pgm_we) + int'(gfxk_we) + int'(gfxh_we) + int'(prom_we);
    if (n != 0) begin
      rg = pgm_we ? 0 : gfxk_we ? 1 : gfxh_we ? 2 : 3;
      tests++;
      if (n > 1 || load_done || sbq.size() == 0) begin
        fails++;
        $display("FAIL strobe: %0d strobes, load_done=%0b, %0d writes pending, wr_addr=%0h", n, load_done, sbq.size(), wr_addr);
      end else begin
        e = sbq.pop_front();
        cnt[rg]++;
        if (rg != e.rg || wr_addr !== e.a || wr_data !== e.d || cyc != e.due) begin
          fails++;
          $display("FAIL write: got region %0d addr %0h data %0h cycle %0d, expected region %0d addr %0h data %0h cycle %0d",
                   rg, wr_addr, wr_data, cyc, e.rg, e.a, e.d, e.due);
        end
      end
    end
  end
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hi, input bit acc);
    int r;
    exp_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (acc) begin
      r = region_of(a);
      if (r < 4) begin
        e.rg = r;
        e.a = 14'(32'(a) - base_of(r));
        e.d = d;
        e.due = cyc + 2;
        sbq.push_back(e);
        if (m_count < 'hFFFF) m_count++;
      end else m_oor = 1'b1;
    end
    repeat (hi) @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic rand_bytes(input int n, input bit allow_oor);
    for (int i = 0; i < n; i++) begin
      logic [24:0] a;
      a = (allow_oor && $urandom_range(0, 5) == 0) ? 25'($urandom_range(32'h6020, 32'h1FFFFFF)) : 25'($urandom_range(0, 32'h601F));
      send_byte(a, 8'($urandom), $urandom_range(1, 2), 1'b1);
    end
  endtask
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys);
    #1;
    m_count = 0;
    m_oor = 1'b0;
  endtask
  task automatic finish_dl();
    int k;
    bit bad;
    k = 0;
    bad = 1'b0;
    ioctl_download = 1'b0;
    while (!load_done && k < HOLD + 100) begin
      @(posedge clk_sys);
      #1 k++;
      if (!load_done && !core_reset) bad = 1'b1;
      if (load_done && core_reset) bad = 1'b1;
    end
    check("hold_length", 32'(k), 32'(HOLD + 1));
    check("release_together", 32'(bad), 32'd0);
    check("byte_count", 32'(byte_count), 32'(m_count));
    check("load_err", 32'(load_err), 32'(m_oor || m_count != EXP));
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_strobes"}, 32'({pgm_we, gfxk_we, gfxh_we, prom_we}), 32'd0);
  endtask
  initial begin
    bit bad;
    cnt = '{default: 0};
    repeat (3) @(posedge clk_sys);
    #1 check_reset_vals("reset");
    reset = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      @(posedge clk_sys);
      #1 if (!core_reset || load_done) bad = 1'b1;
    end
    check("idle_held", 32'(bad), 32'd0);
    start_dl(8'd0);
    rand_bytes(100, 1'b0);
    ioctl_addr = 25'h10;
    ioctl_dout = 8'hEE;
    ioctl_wr = 1'b1;
    @(posedge clk_sys);
    #1 reset = 1'b1;
    #1 check_reset_vals("abort");
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1 check("abort_core_reset", 32'(core_reset), 32'd1);
    check("abort_byte_count", 32'(byte_count), 32'd0);
    cnt = '{default: 0};
    start_dl(8'd0);
    for (int a = 0; a < EXP; a++) send_byte(25'(a), 8'($urandom), $urandom_range(1, 2), 1'b1);
    finish_dl();
    check("pgm_pulses", 32'(cnt[0]), 32'd16384);
    check("gfxk_pulses", 32'(cnt[1]), 32'd4096);
    check("gfxh_pulses", 32'(cnt[2]), 32'd4096);
    check("prom_pulses", 32'(cnt[3]), 32'd32);
    start_dl(8'd0);
    send_byte(25'h6005, 8'h5A, 2, 1'b1);
    send_byte(25'h4ABC, 8'($urandom), 1, 1'b1);
    rand_bytes(40, 1'b1);
    finish_dl();
    start_dl(8'd0);
    rand_bytes(10, 1'b0);
    send_byte(25'h7000, 8'($urandom), 2, 1'b1);
    rand_bytes(5, 1'b0);
    finish_dl();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_byte(25'($urandom_range(0, 32'h601F)), 8'($urandom), 1, 1'b0);
      if (core_reset || !load_done) bad = 1'b1;
    end
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 check("foreign_index_run", 32'(bad), 32'd0);
    check("foreign_index_count", 32'(byte_count), 32'(m_count));
    start_dl(8'd0);
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_load_done", 32'(load_done), 32'd0);
    check("restart_byte_count", 32'(byte_count), 32'd0);
    check("restart_load_err", 32'(load_err), 32'd0);
    rand_bytes(12, 1'b0);
    finish_dl();
    repeat (5) @(posedge clk_sys);
    #1 check("writes_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #10000000;
    $display("FAIL watchdog: run did not complete, %0d writes pending", sbq.size());
    $fatal(1, "watchdog");
  end
endmodule
